// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating membrane, shift leak, threshold spike, refractory hold.
// Optional `LIF_SPIKE_COUNT_EN adds a saturating 16-bit spike_count output.
module lif_neuron #(
  parameter int IN_W       = 8,
  parameter int MEM_W      = 12,
  parameter int THRESH     = 128,
  parameter int V_RESET    = 0,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sum_valid,
  input  logic signed [IN_W-1:0]  sum_in,
  output logic                    spike,
  output logic signed [MEM_W-1:0] v_mem,
  output logic                    refrac_active,
  output logic                    sat_flag
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [15:0]             spike_count
`endif
);

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  localparam int CNT_W = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam logic signed [MEM_W-1:0] THRESH_V  = MEM_W'(THRESH);
  localparam logic signed [MEM_W-1:0] V_RESET_V = MEM_W'(V_RESET);
  localparam logic [CNT_W-1:0]        REFRAC_V  = CNT_W'(REFRAC);

  function automatic logic signed [MEM_W:0] leak_of(input logic signed [MEM_W:0] v);
    if (LEAK_SHIFT == 0) return '0;
    return v >>> LEAK_SHIFT;
  endfunction

  function automatic logic signed [MEM_W-1:0] sat_mem(input logic signed [MEM_W:0] t);
    if (t[MEM_W] != t[MEM_W-1])
      return t[MEM_W] ? {1'b1, {(MEM_W-1){1'b0}}} : {1'b0, {(MEM_W-1){1'b1}}};
    return t[MEM_W-1:0];
  endfunction

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [MEM_W:0]    v_ext_p0;
  logic signed [MEM_W:0]    sum_ext_p0;
  logic signed [MEM_W:0]    t_p0;
  logic signed [MEM_W-1:0]  t_sat_p0;
  logic                     t_ovf_p0;
  logic                     fire_p0;

  // Stage p0: leak + integrate at one extra bit, then clamp and threshold
  always_comb begin
    v_ext_p0   = {v_mem[MEM_W-1], v_mem};
    sum_ext_p0 = {{(MEM_W+1-IN_W){sum_in[IN_W-1]}}, sum_in};
    t_p0       = v_ext_p0 - leak_of(v_ext_p0) + sum_ext_p0;
    t_sat_p0   = sat_mem(t_p0);
    t_ovf_p0   = (t_p0[MEM_W] != t_p0[MEM_W-1]);
    fire_p0    = (t_sat_p0 >= THRESH_V);
  end

  // Stage p1: registered membrane, spike and refractory control
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INTEGRATE;
      cnt           <= '0;
      spike         <= 1'b0;
      v_mem         <= '0;
      refrac_active <= 1'b0;
      sat_flag      <= 1'b0;
`ifdef LIF_SPIKE_COUNT_EN
      spike_count   <= '0;
`endif
    end else begin
      spike <= 1'b0;
      if (sum_valid) begin
        case (state)
          INTEGRATE: begin
            if (t_ovf_p0) sat_flag <= 1'b1;
            if (fire_p0) begin
              spike <= 1'b1;
              v_mem <= V_RESET_V;
`ifdef LIF_SPIKE_COUNT_EN
              if (spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
`endif
              if (REFRAC > 0) begin
                state         <= REFRACTORY;
                cnt           <= REFRAC_V;
                refrac_active <= 1'b1;
              end
            end else begin
              v_mem <= t_sat_p0;
            end
          end
          REFRACTORY: begin
            // The valid step that brings the counter to zero is still discarded
            v_mem <= V_RESET_V;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state         <= INTEGRATE;
              refrac_active <= 1'b0;
            end
          end
          default: state <= INTEGRATE;
        endcase
      end
    end
  end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron that consumes the signed Q1.7 weighted sum produced by the 5-input pixel/weight MAC, one value per timestep. It integrates each valid sum into a saturating membrane potential, applies shift-based leak, and fires a one-cycle spike on reaching threshold, followed by a refractory period. It is the receiving end of the MAC sum interface, placed between the MAC and the next spiking layer.

## Interface
- IN_W, 8: width of `sum_in`, signed Q1.7.
- MEM_W, 12: membrane width, signed Q(MEM_W-7).7; must be greater than IN_W.
- THRESH, 128: firing threshold in membrane LSBs (128 = 1.0).
- V_RESET, 0: membrane value after a spike and during refractory.
- LEAK_SHIFT, 3: leak is `v >>> LEAK_SHIFT`; 0 disables leak.
- REFRAC, 2: number of refractory timesteps after a spike; 0 disables refractory.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- sum_valid, input, 1: `sum_in` holds one timestep's MAC sum.
- sum_in, input, IN_W: signed Q1.7 sum from the MAC.
- spike, output, 1: registered; one-cycle pulse.
- v_mem, output, MEM_W: registered signed membrane potential.
- refrac_active, output, 1: high while in REFRACTORY.
- sat_flag, output, 1: sticky; set when any update saturates; cleared only by `rst`.

## Operation
- States: INTEGRATE and REFRACTORY. Reset enters INTEGRATE.
- INTEGRATE, `sum_valid`=1:
  - Compute `t = v - (LEAK_SHIFT ? v >>> LEAK_SHIFT : 0) + sext(sum_in)` at MEM_W+1 bits.
  - Clamp `t` to [-2^(MEM_W-1), 2^(MEM_W-1)-1]; if clamped, set `sat_flag`.
  - If clamped `t >= THRESH` (signed compare):
    - `spike` <= 1 and `v_mem` <= V_RESET.
    - If REFRAC > 0: enter REFRACTORY and load the refractory counter with REFRAC.
  - Otherwise `v_mem` <= clamped `t`.
- REFRACTORY, `sum_valid`=1:
  - `sum_in` is discarded and `v_mem` is held at V_RESET.
  - The counter decrements; when it reaches 0, return to INTEGRATE.
  - The timestep that decrements the counter to 0 is still ignored.
- `sum_valid`=0 in either state:
  - No leak, no counter change, `v_mem` held, `spike`=0.
- Leak uses an arithmetic shift. Negative `v` leaks toward 0 and rounds toward -inf.
- `spike` is never high on two consecutive cycles unless REFRAC=0 and `sum_valid` is high on both cycles.

## Timing
- Reset values: `spike`=0, `v_mem`=0, `refrac_active`=0, `sat_flag`=0. Internal state: INTEGRATE, counter=0.
- Latency: 1 cycle. The `spike` and `v_mem` updates for a valid sum in cycle N are visible in cycle N+1.
- Throughput: one sum per cycle; no backpressure and no ready signal.
- `refrac_active` rises in the same cycle as `spike`. It falls in the cycle after the last ignored valid timestep.
- `rst` asserted mid-refractory or mid-integration: the next cycle shows all reset values. Any `sum_valid` in the reset cycle is dropped.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined: adds output `spike_count`, 16 bits.
  - Increments on every spike and saturates at 16'hFFFF.
  - Resets to 0 on `rst`.
  - Updates in the same cycle as `spike`.
- `LIF_SPIKE_COUNT_EN` undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold `rst` for 2 cycles with `sum_valid`=1 and `sum_in`=8'h7F → all outputs 0; `v_mem` stays 0 after release until the first valid sum.
- Integrate and fire, defaults: `sum_in`=64 valid on 3 consecutive cycles → `v_mem` 64, then 120, then 0. `spike`=1 on the third update only; `refrac_active`=1 from then.
- Refractory, defaults, continuing the previous scenario: 3 further valid sums of 127 → the first two are ignored (`v_mem`=0). `refrac_active` drops after the second. The third gives `v_mem`=127 and no spike (127 < 128).
- Valid gaps: `v_mem`=120, then `sum_valid`=0 for 5 cycles → `v_mem` stays 120 with no leak. Next valid `sum_in`=0 → `v_mem`=105.
- Saturation, LEAK_SHIFT=0: `sum_in`=-128 on 17 valid cycles → `v_mem` reaches -2048 after 16 updates and holds. `sat_flag` sets on the 17th and stays set after a later positive input.
- With `LIF_SPIKE_COUNT_EN`, REFRAC=0, THRESH=1: `sum_in`=1 valid for 3 cycles → `spike` high on 3 consecutive cycles; `spike_count`=3.
